// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches over a req/ack memory
// handshake and exposes the decoded IR fields to the control unit and datapath.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic        IR_Write,
  input  logic        pc_load,
  input  logic [31:0] pc_load_addr,
  input  logic        err_clr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm_i,
  output logic [31:0] imm_u,
  output logic        if_busy,
  output logic        if_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] addr_q;
  logic [31:0] ld_addr_q;
  logic        req_q;
  logic        busy_q;
  logic        err_q;
  logic        inc_pend_q;
  logic        ld_pend_q;
  logic [7:0]  cnt_q;

  // A load arriving in the completing cycle still counts: last load wins.
  logic        ld_now_d;
  logic [31:0] ld_target_d;
  assign ld_now_d    = ld_pend_q | pc_load;
  assign ld_target_d = pc_load ? pc_load_addr : ld_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INST;
      addr_q     <= RESET_PC;
      ld_addr_q  <= 32'h0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      inc_pend_q <= 1'b0;
      ld_pend_q  <= 1'b0;
      cnt_q      <= 8'h0;
    end else begin
      // Any error set below is a later assignment, so it overrides the clear.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (IR_Write) begin
            if (pc_q[1:0] == 2'b00) begin
              state_q    <= S_WAIT;
              req_q      <= 1'b1;
              addr_q     <= pc_q;
              busy_q     <= 1'b1;
              cnt_q      <= 8'h0;
              inc_pend_q <= PC_Write;
              ld_pend_q  <= pc_load;
              ld_addr_q  <= pc_load_addr;
            end else begin
              ir_q  <= NOP_INST;
              err_q <= 1'b1;
              if (pc_load) pc_q <= pc_load_addr;
            end
          end else if (pc_load) begin
            pc_q <= pc_load_addr;
          end else if (PC_Write) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
            inc_pend_q <= 1'b0;
            ld_pend_q  <= 1'b0;
            if (ld_now_d)        pc_q <= ld_target_d;
            else if (inc_pend_q) pc_q <= pc_q + 32'd4;
          end else if (cnt_q == TO_LAST) begin
            ir_q       <= NOP_INST;
            err_q      <= 1'b1;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
            inc_pend_q <= 1'b0;
            ld_pend_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (pc_load) begin
              ld_pend_q <= 1'b1;
              ld_addr_q <= pc_load_addr;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign if_busy   = busy_q;
  assign if_err    = err_q;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u  = {ir_q[31:12], 12'b0};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: table of fetch transactions through a scoreboard,
// plus hand-written timeout, load, misalignment, wrap and reset sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, PC_Write, IR_Write, pc_load, err_clr, imem_ack;
  logic [31:0] pc_load_addr, imem_rdata;
  logic        imem_req, if_busy, if_err;
  logic [31:0] imem_addr, PC, IR, imm_i, imm_u;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .IR_Write(IR_Write),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr), .err_clr(err_clr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .PC(PC), .IR(IR), .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm_i(imm_i),
    .imm_u(imm_u), .if_busy(if_busy), .if_err(if_err)
  );

  typedef struct {
    logic        pcw;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
  } vec_t;

  vec_t vecs[4];
  vec_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  initial begin
    int cyc;
    logic addr_ok;
    vec_t e;

    vecs[0] = '{1'b1, 0, 32'h00500093, 32'h0, 32'h4, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00, 32'h5, 32'h00500000};
    vecs[1] = '{1'b1, 5, 32'h123450B7, 32'h4, 32'h8, 7'h37, 5'd1, 3'd5, 5'd8, 5'd3, 7'h09, 32'h123, 32'h12345000};
    vecs[2] = '{1'b0, 2, 32'hFFF10113, 32'h8, 32'h8, 7'h13, 5'd2, 3'd0, 5'd2, 5'd31, 7'h7F, 32'hFFFFFFFF, 32'hFFF10000};
    vecs[3] = '{1'b1, 0, 32'h40B50533, 32'h8, 32'hC, 7'h33, 5'd10, 3'd0, 5'd10, 5'd11, 7'h20, 32'h40B, 32'h40B50000};

    rst = 1'b1; PC_Write = 0; IR_Write = 0; pc_load = 0; err_clr = 0;
    imem_ack = 0; pc_load_addr = 0; imem_rdata = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", IR, 32'h13);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_busy", 32'(if_busy), 32'h0);
    chk("rst_err", 32'(if_err), 32'h0);

    // Table-driven fetches through the scoreboard.
    for (int i = 0; i < 4; i++) begin
      IR_Write = 1'b1; PC_Write = vecs[i].pcw;
      sb.push_back(vecs[i]);
      tick();
      IR_Write = 1'b0; PC_Write = 1'b0;
      cyc = 0; addr_ok = 1'b1;
      while (if_busy && cyc < 300) begin
        if (!imem_req || imem_addr !== vecs[i].exp_addr) addr_ok = 1'b0;
        if (cyc == vecs[i].delay) begin imem_ack = 1'b1; imem_rdata = vecs[i].rdata; end
        tick();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_0000;
        cyc++;
      end
      e = sb.pop_front();
      chk($sformatf("v%0d_busy_cycles", i), 32'(cyc), 32'(e.delay + 1));
      chk($sformatf("v%0d_req_addr_stable", i), 32'(addr_ok), 32'h1);
      chk($sformatf("v%0d_req_drop", i), 32'(imem_req), 32'h0);
      chk($sformatf("v%0d_ir", i), IR, e.rdata);
      chk($sformatf("v%0d_pc", i), PC, e.exp_pc);
      chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(e.opc));
      chk($sformatf("v%0d_rd", i), 32'(rd), 32'(e.rd));
      chk($sformatf("v%0d_funct3", i), 32'(funct3), 32'(e.f3));
      chk($sformatf("v%0d_rs1", i), 32'(rs1), 32'(e.rs1));
      chk($sformatf("v%0d_rs2", i), 32'(rs2), 32'(e.rs2));
      chk($sformatf("v%0d_funct7", i), 32'(funct7), 32'(e.f7));
      chk($sformatf("v%0d_imm_i", i), imm_i, e.imm_i);
      chk($sformatf("v%0d_imm_u", i), imm_u, e.imm_u);
    end

    // Timeout: no ack, PC_Write requested but PC must stay.
    IR_Write = 1'b1; PC_Write = 1'b1;
    tick();
    IR_Write = 1'b0; PC_Write = 1'b0;
    cyc = 0;
    while (if_busy && cyc < 300) begin tick(); cyc++; end
    chk("to_wait_cycles", 32'(cyc), 32'd15);
    chk("to_req", 32'(imem_req), 32'h0);
    chk("to_ir", IR, 32'h13);
    chk("to_err", 32'(if_err), 32'h1);
    chk("to_pc", PC, 32'hC);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_err_clr", 32'(if_err), 32'h0);

    // pc_load during WAIT: last load wins over PC+4.
    IR_Write = 1'b1; PC_Write = 1'b1;
    tick();
    IR_Write = 1'b0; PC_Write = 1'b0;
    chk("ld_addr", imem_addr, 32'hC);
    pc_load = 1'b1; pc_load_addr = 32'h40;
    tick();
    pc_load_addr = 32'h80;
    tick();
    pc_load = 1'b0; pc_load_addr = 32'h0;
    imem_ack = 1'b1; imem_rdata = 32'h00A00093;
    tick();
    imem_ack = 1'b0;
    chk("ld_busy", 32'(if_busy), 32'h0);
    chk("ld_pc", PC, 32'h80);
    chk("ld_ir", IR, 32'h00A00093);
    chk("ld_imm_i", imm_i, 32'hA);

    // Misaligned PC: no request, NOP, sticky error.
    pc_load = 1'b1; pc_load_addr = 32'h102;
    tick();
    pc_load = 1'b0;
    chk("mis_pc_loaded", PC, 32'h102);
    IR_Write = 1'b1;
    tick();
    IR_Write = 1'b0;
    chk("mis_req", 32'(imem_req), 32'h0);
    chk("mis_busy", 32'(if_busy), 32'h0);
    chk("mis_ir", IR, 32'h13);
    chk("mis_err", 32'(if_err), 32'h1);
    chk("mis_pc", PC, 32'h102);
    IR_Write = 1'b1; err_clr = 1'b1;
    tick();
    IR_Write = 1'b0; err_clr = 1'b0;
    chk("mis_err_wins", 32'(if_err), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("mis_err_clr", 32'(if_err), 32'h0);

    // PC wrap.
    pc_load = 1'b1; pc_load_addr = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0; PC_Write = 1'b1;
    tick();
    PC_Write = 1'b0;
    chk("wrap_pc", PC, 32'h0);

    // Reset mid-fetch with a coincident ack, then a stray ack in IDLE.
    pc_load = 1'b1; pc_load_addr = 32'h200;
    tick();
    pc_load = 1'b0; IR_Write = 1'b1; PC_Write = 1'b1;
    tick();
    IR_Write = 1'b0; PC_Write = 1'b0;
    chk("rw_req", 32'(imem_req), 32'h1);
    chk("rw_addr", imem_addr, 32'h200);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk("rw_pc", PC, 32'h0);
    chk("rw_ir", IR, 32'h13);
    chk("rw_req_after", 32'(imem_req), 32'h0);
    chk("rw_addr_after", imem_addr, 32'h0);
    chk("rw_busy", 32'(if_busy), 32'h0);
    chk("rw_err", 32'(if_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
